// File: rtl/if_fetch_stage.sv
// rtl/if_fetch_stage.sv - instruction fetch stage: PC, imem req/ack, IF/ID register
module if_fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    input  logic        stall_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_ack_i,
    input  logic [31:0] imem_data_i,
    output logic        if_valid_o,
    output logic [31:0] if_pc_o,
    output logic [31:0] if_inst_o
);

    // FETCH: request to pc_q outstanding
    // HOLD : word parked in the buffer while IF/ID is stalled, no request
    // DROP : wrong-path request to drop_addr_q outstanding, pc_q already redirected
    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_HOLD  = 2'd1,
        S_DROP  = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] drop_addr_q, drop_addr_d;
    logic [31:0] buf_pc_q, buf_pc_d;
    logic [31:0] buf_inst_q, buf_inst_d;
    logic        ifid_valid_q, ifid_valid_d;
    logic [31:0] ifid_pc_q, ifid_pc_d;
    logic [31:0] ifid_inst_q, ifid_inst_d;

    logic [31:0] pc_plus4;
    logic [31:0] redirect_pc_aligned;

    assign pc_plus4            = pc_q + 32'd4;
    assign redirect_pc_aligned = redirect_pc_i & 32'hFFFF_FFFC;

    // The address bus shows the in-flight request; in DROP that is the stale address
    assign imem_req_o  = !rst && (state_q != S_HOLD);
    assign imem_addr_o = (state_q == S_DROP) ? drop_addr_q : pc_q;

    assign if_valid_o = ifid_valid_q;
    assign if_pc_o    = ifid_pc_q;
    assign if_inst_o  = ifid_inst_q;

    // Next-state: redirect flushes everything; otherwise advance per state, stall freezes IF/ID
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        drop_addr_d  = drop_addr_q;
        buf_pc_d     = buf_pc_q;
        buf_inst_d   = buf_inst_q;
        ifid_valid_d = ifid_valid_q;
        ifid_pc_d    = ifid_pc_q;
        ifid_inst_d  = ifid_inst_q;

        if (redirect_i) begin
            ifid_valid_d = 1'b0;
            ifid_inst_d  = NOP_INST;
            pc_d         = redirect_pc_aligned;
            case (state_q)
                S_FETCH: begin
                    if (imem_ack_i) begin
                        state_d = S_FETCH;
                    end else begin
                        state_d     = S_DROP;
                        drop_addr_d = pc_q;
                    end
                end
                S_HOLD:  state_d = S_FETCH;
                S_DROP:  state_d = imem_ack_i ? S_FETCH : S_DROP;
                default: state_d = S_FETCH;
            endcase
        end else begin
            case (state_q)
                S_FETCH: begin
                    if (imem_ack_i) begin
                        pc_d = pc_plus4;
                        if (stall_i) begin
                            buf_pc_d   = pc_q;
                            buf_inst_d = imem_data_i;
                            state_d    = S_HOLD;
                        end else begin
                            ifid_valid_d = 1'b1;
                            ifid_pc_d    = pc_q;
                            ifid_inst_d  = imem_data_i;
                        end
                    end else if (!stall_i) begin
                        ifid_valid_d = 1'b0;
                        ifid_inst_d  = NOP_INST;
                    end
                end
                S_HOLD: begin
                    if (!stall_i) begin
                        ifid_valid_d = 1'b1;
                        ifid_pc_d    = buf_pc_q;
                        ifid_inst_d  = buf_inst_q;
                        state_d      = S_FETCH;
                    end
                end
                S_DROP: begin
                    if (!stall_i) begin
                        ifid_valid_d = 1'b0;
                        ifid_inst_d  = NOP_INST;
                    end
                    if (imem_ack_i) begin
                        state_d = S_FETCH;
                    end
                end
                default: state_d = S_FETCH;
            endcase
        end
    end

    // State and pipeline registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_FETCH;
            pc_q         <= RESET_PC;
            drop_addr_q  <= 32'd0;
            buf_pc_q     <= 32'd0;
            buf_inst_q   <= 32'd0;
            ifid_valid_q <= 1'b0;
            ifid_pc_q    <= 32'd0;
            ifid_inst_q  <= NOP_INST;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            drop_addr_q  <= drop_addr_d;
            buf_pc_q     <= buf_pc_d;
            buf_inst_q   <= buf_inst_d;
            ifid_valid_q <= ifid_valid_d;
            ifid_pc_q    <= ifid_pc_d;
            ifid_inst_q  <= ifid_inst_d;
        end
    end

endmodule

// File: tb/tb_if_fetch_stage.sv
// tb/tb_if_fetch_stage.sv - directed bench with behavioural fetch model for if_fetch_stage
module tb_if_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam logic [31:0] K   = 32'hA5A5_0000;

    logic        clk;
    logic        rst;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        stall_i;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_ack_i;
    logic [31:0] imem_data_i;
    logic        if_valid_o;
    logic [31:0] if_pc_o;
    logic [31:0] if_inst_o;

    if_fetch_stage #(
        .RESET_PC(32'h0000_0000),
        .NOP_INST(NOP)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .redirect_i   (redirect_i),
        .redirect_pc_i(redirect_pc_i),
        .stall_i      (stall_i),
        .imem_req_o   (imem_req_o),
        .imem_addr_o  (imem_addr_o),
        .imem_ack_i   (imem_ack_i),
        .imem_data_i  (imem_data_i),
        .if_valid_o   (if_valid_o),
        .if_pc_o      (if_pc_o),
        .if_inst_o    (if_inst_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors;
    int miscompares;

    // Memory behaviour
    logic ack_tied;
    int   mem_wait;
    int   wcnt;

    // Behavioural model: sequential pointer, parked word, wrong-path flag
    logic [31:0] m_pc;
    logic        m_wrong;
    logic [31:0] m_stale;
    logic        m_buf_v;
    logic [31:0] m_buf_pc;
    logic [31:0] m_buf_inst;
    logic        e_valid;
    logic [31:0] e_pc;
    logic [31:0] e_inst;

    // Outputs sampled in the most recent cycle
    logic        s_req;
    logic [31:0] s_addr;
    logic        s_valid;
    logic [31:0] s_pc;
    logic [31:0] s_inst;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        m_pc    = 32'h0;
        m_wrong = 1'b0;
        m_stale = 32'h0;
        m_buf_v = 1'b0;
        e_valid = 1'b0;
        e_pc    = 32'h0;
        e_inst  = NOP;
        wcnt    = 0;
    endtask

    // One clock cycle: drive inputs, compare every output, advance the model
    task automatic cycle(input logic r, input logic red, input logic [31:0] rpc, input logic st);
        logic        exp_req;
        logic [31:0] exp_addr;
        logic        ack;
        logic        got;
        logic [31:0] w_pc;
        logic [31:0] w_inst;
        @(negedge clk);
        rst           = r;
        redirect_i    = red;
        redirect_pc_i = rpc;
        stall_i       = st;
        exp_req  = !r && !m_buf_v;
        exp_addr = m_wrong ? m_stale : m_pc;
        ack      = ack_tied ? 1'b1 : (exp_req && (wcnt == mem_wait));
        imem_ack_i  = ack;
        imem_data_i = imem_addr_o ^ K;
        #1;
        s_req   = imem_req_o;
        s_addr  = imem_addr_o;
        s_valid = if_valid_o;
        s_pc    = if_pc_o;
        s_inst  = if_inst_o;
        check("req", {31'd0, s_req}, {31'd0, exp_req});
        if (exp_req) check("addr", s_addr, exp_addr);
        check("valid", {31'd0, s_valid}, {31'd0, e_valid});
        check("if_pc", s_pc, e_pc);
        check("if_inst", s_inst, e_inst);

        if (r) begin
            model_reset();
        end else begin
            if (exp_req && !ack) wcnt++;
            else wcnt = 0;
            if (red) begin
                if (exp_req && !ack) begin
                    if (!m_wrong) m_stale = m_pc;
                    m_wrong = 1'b1;
                end else begin
                    m_wrong = 1'b0;
                end
                m_pc    = rpc & 32'hFFFF_FFFC;
                m_buf_v = 1'b0;
                e_valid = 1'b0;
                e_inst  = NOP;
            end else begin
                got    = 1'b0;
                w_pc   = 32'h0;
                w_inst = 32'h0;
                if (exp_req && ack) begin
                    if (m_wrong) begin
                        m_wrong = 1'b0;
                    end else begin
                        got    = 1'b1;
                        w_pc   = m_pc;
                        w_inst = m_pc ^ K;
                        m_pc   = m_pc + 32'd4;
                    end
                end
                if (!st) begin
                    if (m_buf_v) begin
                        e_valid = 1'b1;
                        e_pc    = m_buf_pc;
                        e_inst  = m_buf_inst;
                        m_buf_v = 1'b0;
                    end else if (got) begin
                        e_valid = 1'b1;
                        e_pc    = w_pc;
                        e_inst  = w_inst;
                    end else begin
                        e_valid = 1'b0;
                        e_inst  = NOP;
                    end
                end else if (got) begin
                    m_buf_v    = 1'b1;
                    m_buf_pc   = w_pc;
                    m_buf_inst = w_inst;
                end
            end
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 32'h0, 1'b0);
    endtask

    task automatic do_reset();
        cycle(1'b1, 1'b0, 32'h0, 1'b0);
    endtask

    initial begin
        vectors       = 0;
        miscompares   = 0;
        rst           = 1'b1;
        redirect_i    = 1'b0;
        redirect_pc_i = 32'h0;
        stall_i       = 1'b0;
        imem_ack_i    = 1'b0;
        imem_data_i   = 32'h0;
        ack_tied      = 1'b1;
        mem_wait      = 0;
        model_reset();
        repeat (2) @(posedge clk);

        // Zero-wait memory, ack tied high
        do_reset();
        do_reset();
        check("rst_req", {31'd0, s_req}, 32'd0);
        check("rst_valid", {31'd0, s_valid}, 32'd0);
        check("rst_inst", s_inst, NOP);
        check("rst_pc", s_pc, 32'h0);
        run(1);
        check("first_addr", s_addr, 32'h0);
        check("first_req", {31'd0, s_req}, 32'd1);
        run(1);
        check("seq_addr4", s_addr, 32'h4);
        check("seq_pc0", s_pc, 32'h0);
        check("seq_inst0", s_inst, 32'hA5A5_0000);
        run(4);
        check("seq_addr14", s_addr, 32'h14);
        check("seq_pc10", s_pc, 32'h10);

        // Two wait states
        do_reset();
        ack_tied = 1'b0;
        mem_wait = 2;
        run(2);
        check("ws_addr_held", s_addr, 32'h0);
        run(2);
        check("ws_pc0", s_pc, 32'h0);
        check("ws_addr4", s_addr, 32'h4);
        run(1);
        check("ws_bubble_valid", {31'd0, s_valid}, 32'd0);
        check("ws_bubble_inst", s_inst, NOP);
        run(2);
        check("ws_pc4", s_pc, 32'h4);
        check("ws_valid4", {31'd0, s_valid}, 32'd1);
        run(6);

        // Stall for 3 cycles while 0x10 is acked
        ack_tied = 1'b1;
        do_reset();
        run(4);
        cycle(1'b0, 1'b0, 32'h0, 1'b1);
        check("st_addr10", s_addr, 32'h10);
        cycle(1'b0, 1'b0, 32'h0, 1'b1);
        check("st_hold_req", {31'd0, s_req}, 32'd0);
        check("st_hold_pc", s_pc, 32'hC);
        cycle(1'b0, 1'b0, 32'h0, 1'b1);
        run(1);
        check("st_rel_req", {31'd0, s_req}, 32'd0);
        run(1);
        check("st_pc10", s_pc, 32'h10);
        check("st_addr14", s_addr, 32'h14);
        run(1);
        check("st_pc14", s_pc, 32'h14);

        // Redirect while 0x20 outstanding, ack delayed
        do_reset();
        run(8);
        ack_tied = 1'b0;
        mem_wait = 2;
        cycle(1'b0, 1'b1, 32'h0000_0102, 1'b0);
        check("rd_addr20", s_addr, 32'h20);
        run(1);
        check("rd_drop_addr", s_addr, 32'h20);
        check("rd_drop_valid", {31'd0, s_valid}, 32'd0);
        run(2);
        check("rd_new_addr", s_addr, 32'h100);
        run(3);
        check("rd_pc100", s_pc, 32'h100);
        check("rd_inst100", s_inst, 32'hA5A5_0100);
        check("rd_valid100", {31'd0, s_valid}, 32'd1);

        // Redirect with stall while in HOLD
        ack_tied = 1'b1;
        do_reset();
        run(1);
        cycle(1'b0, 1'b0, 32'h0, 1'b1);
        cycle(1'b0, 1'b1, 32'h0000_0100, 1'b1);
        run(1);
        check("hr_valid", {31'd0, s_valid}, 32'd0);
        check("hr_addr", s_addr, 32'h100);
        run(1);
        check("hr_pc", s_pc, 32'h100);

        // PC wrap, then reset in the middle of DROP
        do_reset();
        cycle(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0);
        run(1);
        check("wr_addr_top", s_addr, 32'hFFFF_FFFC);
        run(1);
        check("wr_addr_zero", s_addr, 32'h0);
        check("wr_inst_top", s_inst, 32'h5A5A_FFFC);
        run(1);
        ack_tied = 1'b0;
        mem_wait = 3;
        cycle(1'b0, 1'b1, 32'h0000_0200, 1'b0);
        do_reset();
        check("wr_rst_req", {31'd0, s_req}, 32'd0);
        run(1);
        check("wr_rst_addr", s_addr, 32'h0);
        check("wr_rst_valid", {31'd0, s_valid}, 32'd0);
        check("wr_rst_inst", s_inst, NOP);

        // Mixed stalls, waits and redirects, checked against the model only
        mem_wait = 1;
        for (int i = 0; i < 40; i++) begin
            cycle(1'b0, (i == 17) || (i == 29), (i == 17) ? 32'h0000_0041 : 32'h0000_0080,
                  (i % 5) == 2);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/if_fetch_stage.md
Name: if_fetch_stage

Overview:
- Instruction-fetch stage of the 5-stage pipelined CPU.
- Holds the PC and issues requests to instruction memory over a req/ack handshake. Registers the fetched word into the IF/ID pipeline register.
- Consumes the 32-bit redirect address produced by the next-PC select mux (PC+4 vs branch/jump target chosen in EX).
- Absorbs memory latency and downstream stalls, and discards wrong-path fetches.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset.
NOP_INST, 32'h0000_0013, instruction presented on if_inst_o when the slot is a bubble (addi x0,x0,0).

Ports:
clk  input  1  pipeline clock; all state updates on rising edge
rst  input  1  synchronous, active-high reset
redirect_i  input  1  EX resolved a taken branch/jump; flush and reload PC
redirect_pc_i  input  32  new PC from the next-PC select mux; valid when redirect_i=1
stall_i  input  1  hazard unit freezes IF/ID (load-use etc.)
imem_req_o  output  1  fetch request
imem_addr_o  output  32  fetch address; word aligned
imem_ack_i  input  1  memory returns imem_data_i this cycle; may assert in the same cycle as the request
imem_data_i  input  32  fetched instruction
if_valid_o  output  1  IF/ID slot holds a real instruction
if_pc_o  output  32  PC of IF/ID instruction
if_inst_o  output  32  IF/ID instruction; NOP_INST when if_valid_o=0

Behaviour:
- Reset (rst=1 at edge):
  - pc=RESET_PC, state=FETCH, buffer empty.
  - if_valid_o=0, if_pc_o=0, if_inst_o=NOP_INST.
  - imem_req_o=0 during the reset cycle. The first request is issued the cycle after rst deasserts.
  - Reset overrides every other input, including mid-transaction. An ack arriving after reset for a pre-reset request is not expected; memory is reset by the same rst.
- States:
  - FETCH: request outstanding.
  - HOLD: word fetched but IF/ID stalled; stored in 1-entry buffer.
  - DROP: wrong-path request still outstanding; its ack is discarded.
- Request outputs:
  - imem_req_o=1 in FETCH and DROP; 0 in HOLD.
  - imem_addr_o = address of the outstanding request. It must stay stable from first assertion until the ack.
- Address rules:
  - pc increments by 4 and wraps modulo 2^32; 32'hFFFF_FFFC+4 = 0.
  - redirect_pc_i[1:0] is forced to 2'b00.
- FETCH with ack, no stall, no redirect:
  - IF/ID <= {1, pc, imem_data_i}.
  - pc <= pc+4; stay in FETCH.
  - Back-to-back fetches sustain 1 instruction/cycle with a zero-wait memory.
- FETCH without ack, no stall: IF/ID <= bubble (valid=0, inst=NOP_INST, pc unchanged).
- Stall, general rule: when stall_i=1, IF/ID holds its current contents (all three outputs unchanged).
- FETCH with ack and stall:
  - buffer <= {pc, imem_data_i}; pc <= pc+4; state <= HOLD.
- HOLD:
  - While stall_i=1, buffer and IF/ID hold.
  - First cycle with stall_i=0: IF/ID <= {1, buffer}; state <= FETCH; the next request issues that same cycle, combinationally from state.
- Redirect (redirect_i=1) has the highest priority after rst and overrides stall_i:
  - IF/ID <= bubble; buffer cleared.
  - pc <= {redirect_pc_i[31:2],2'b00}.
  - Next state:
    - FETCH if in FETCH with ack this cycle (data dropped), or if in HOLD.
    - DROP if in FETCH without ack this cycle.
    - Remains DROP if already in DROP without ack; ack in DROP -> FETCH.
- DROP:
  - Keeps old address until ack; acked data is discarded.
  - IF/ID <= bubble each cycle unless stall_i=1, in which case IF/ID holds.
  - On ack -> FETCH at the redirected pc next cycle.
- No instruction is ever duplicated or skipped on the sequential path. No wrong-path instruction ever reaches if_valid_o=1.

Test Plan:
- Reset release, zero-wait memory with ack tied 1, mem[a]=a^32'hA5A5_0000 -> imem_addr_o 0,4,8,...; if_valid_o=1 from cycle 2; if_pc_o/if_inst_o track with 1-cycle latency; NOP_INST and valid=0 during reset.
- Two-wait-state memory (ack every 3rd cycle) -> each address held 3 cycles; two bubbles (valid=0, inst=32'h13) between instructions; pc sequence unchanged.
- stall_i=1 for 3 cycles while ack arrives at pc=0x10 -> IF/ID frozen at pc 0x0C; imem_req_o=0 for the held cycles; on release if_pc_o=0x10, then 0x14; no skip, no duplicate.
- Redirect: redirect_pc_i=0x0000_0102 while request to 0x20 outstanding with ack delayed 2 cycles -> data for 0x20 discarded; next request addr 0x100; if_valid_o=0 until 0x100 arrives.
- Redirect with stall_i=1 simultaneously in HOLD -> IF/ID flushed (valid=0), buffer discarded, next fetch 0x100.
- PC wrap: redirect to 0xFFFF_FFFC, ack tied 1 -> addresses 0xFFFF_FFFC, 0x0000_0000; rst asserted mid-DROP -> outputs return to reset values next cycle, fetch restarts at RESET_PC.
